k_gray_wptr_full_gen: RTL and testbench

//  Write-side pointer and flag generator for the dual-clock FIFO. Keeps an
//  (ADDR_W+1)-bit binary/Gray write pointer and drives the RAM write address.

---
 rtl/k_gray_wptr_full_gen.sv | 76 +++++++
 tb/tb_k_gray_wptr_full_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/k_gray_wptr_full_gen.sv
// Write-side pointer and flag generator for a dual-clock FIFO: binary/Gray write
// pointer, read-pointer synchroniser, registered full/almost_full and sticky overflow.
module k_gray_wptr_full_gen #(
    parameter int ADDR_W       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic [ADDR_W:0]   rptr_gray_i,
    input  logic              clr_err_i,
    output logic              push_ok_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [ADDR_W:0]   wptr_gray_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              ovf_err_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(DEPTH - AFULL_THRESH);

    logic [ADDR_W:0]                   wbin_q, wbin_d;
    logic [ADDR_W:0]                   wgray_q, wgray_d;
    logic [SYNC_STAGES-1:0][ADDR_W:0]  rq_q;
    logic [ADDR_W:0]                   rq_s, rbin_s, used;
    logic                              full_q, full_d;
    logic                              afull_q, afull_d;
    logic                              ovf_q, ovf_d;
    logic                              push_ok;

    assign push_ok = inc_i & ~full_q;
    assign wbin_d  = wbin_q + {{ADDR_W{1'b0}}, push_ok};
    assign wgray_d = wbin_d ^ (wbin_d >> 1);
    assign rq_s    = rq_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDR_W; i++)
            rbin_s[i] = ^(rq_s >> i);
    end

    assign used    = wbin_d - rbin_s;
    assign full_d  = (wgray_d == {~rq_s[ADDR_W:ADDR_W-1], rq_s[ADDR_W-2:0]});
    assign afull_d = (used >= AFULL_LVL);
    // A new overflow attempt outranks a clear on the same edge.
    assign ovf_d   = (inc_i & full_q) | (ovf_q & ~clr_err_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq_q    <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq_q[0] <= rptr_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                rq_q[i] <= rq_q[i-1];
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign push_ok_o     = push_ok;
    assign waddr_o       = wbin_q[ADDR_W-1:0];
    assign wptr_gray_o   = wgray_q;
    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign ovf_err_o     = ovf_q;
endmodule

// File: tb/tb_k_gray_wptr_full_gen.sv
// Directed bench for k_gray_wptr_full_gen (ADDR_W=4, SYNC_STAGES=2, AFULL_THRESH=2).
module tb_k_gray_wptr_full_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc_i = 1'b0;
    logic [4:0] rptr_gray_i = '0;
    logic       clr_err_i = 1'b0;
    logic       push_ok_o;
    logic [3:0] waddr_o;
    logic [4:0] wptr_gray_o;
    logic       full_o, almost_full_o, ovf_err_o;

    int n_chk = 0;
    int n_err = 0;

    k_gray_wptr_full_gen #(.ADDR_W(4), .SYNC_STAGES(2), .AFULL_THRESH(2)) dut (
        .clk(clk), .rst_n(rst_n), .inc_i(inc_i), .rptr_gray_i(rptr_gray_i),
        .clr_err_i(clr_err_i), .push_ok_o(push_ok_o), .waddr_o(waddr_o),
        .wptr_gray_o(wptr_gray_o), .full_o(full_o), .almost_full_o(almost_full_o),
        .ovf_err_o(ovf_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int k);
        logic [4:0] b;
        b = 5'(k);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle's inputs, check the comb strobe, then step past the edge.
    task automatic cyc(input logic inc, input logic clr, input logic exp_pok);
        inc_i = inc;
        clr_err_i = clr;
        #1;
        chk("push_ok", push_ok_o, exp_pok);
        @(posedge clk);
        #1;
        inc_i = 1'b0;
        clr_err_i = 1'b0;
    endtask

    task automatic do_reset();
        inc_i = 1'b0;
        clr_err_i = 1'b0;
        rptr_gray_i = '0;
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pok"},   push_ok_o,     0);
        chk({tag, "_waddr"}, waddr_o,       0);
        chk({tag, "_wgray"}, wptr_gray_o,   0);
        chk({tag, "_full"},  full_o,        0);
        chk({tag, "_afull"}, almost_full_o, 0);
        chk({tag, "_ovf"},   ovf_err_o,     0);
    endtask

    initial begin
        logic [4:0] prev;

        // Reset state
        #3;
        chk_zero("rst");
        do_reset();
        chk_zero("rst_rel");

        // Fill: 16 accepted pushes, then an overflow attempt
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            chk("fill_waddr", waddr_o, k % 16);
            chk("fill_afull", almost_full_o, (k >= 14) ? 1 : 0);
            chk("fill_full",  full_o, (k == 16) ? 1 : 0);
        end
        chk("fill_wgray", wptr_gray_o, 5'b11000);
        chk("fill_ovf0", ovf_err_o, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("ovf_waddr", waddr_o, 0);
        chk("ovf_wgray", wptr_gray_o, 5'b11000);
        chk("ovf_set", ovf_err_o, 1);
        chk("ovf_full", full_o, 1);

        // One entry read: full falls three edges later
        rptr_gray_i = 5'b00001;
        cyc(1'b0, 1'b0, 1'b0);
        chk("rd_e1_full", full_o, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rd_e2_full", full_o, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rd_e3_full", full_o, 0);
        chk("rd_e3_afull", almost_full_o, 1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("refill_full", full_o, 1);
        chk("refill_waddr", waddr_o, 1);
        chk("refill_wgray", wptr_gray_o, 5'b11001);

        // Sticky overflow: clear, then clear racing a new attempt
        chk("ovf_still", ovf_err_o, 1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("ovf_clr", ovf_err_o, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("ovf_set_wins", ovf_err_o, 1);
        chk("ovf_wgray_hold", wptr_gray_o, 5'b11001);

        // Wrap with a reader that keeps up
        do_reset();
        prev = wptr_gray_o;
        for (int k = 1; k <= 40; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            chk("wrap_wgray", wptr_gray_o, gray(k));
            chk("wrap_ham", $countones(prev ^ wptr_gray_o), 1);
            chk("wrap_full", full_o, 0);
            if (k == 31) chk("wrap_g31", wptr_gray_o, 5'b10000);
            if (k == 32) chk("wrap_g32", wptr_gray_o, 5'b00000);
            prev = wptr_gray_o;
            rptr_gray_i = gray(k);
        end

        // Mid-burst reset
        do_reset();
        for (int k = 1; k <= 9; k++) cyc(1'b1, 1'b0, 1'b1);
        chk("mid_waddr9", waddr_o, 9);
        #2;
        inc_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_waddr0", waddr_o, 0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("mid_waddr1", waddr_o, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
